// File: rtl/md_pkg.sv
// Op codes, FSM states and op-class decode helpers shared by the multiply/divide unit.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } md_state_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op <= MD_MSUBU);
  endfunction

  function automatic logic op_is_mul(input logic [3:0] op);
    return (op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU});
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op inside {MD_DIV, MD_DIVU});
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB});
  endfunction

  function automatic logic op_is_acc(input logic [3:0] op);
    return (op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU});
  endfunction

  function automatic logic op_is_sub(input logic [3:0] op);
    return (op inside {MD_MSUB, MD_MSUBU});
  endfunction

endpackage

// File: rtl/md_unit_param_if.sv
// Pipeline-side request/result bundle of the multiply/divide unit.
interface md_unit_param_if #(parameter int WIDTH = 32);
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             start;
  logic             cancel;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (output op, A, B, start, cancel,
                  input  HI, LO, busy, done, div_zero);
  modport slave  (input  op, A, B, start, cancel,
                  output HI, LO, busy, done, div_zero);
endinterface

// File: rtl/md_div_iter.sv
// Restoring radix-2 divider on operand magnitudes, one quotient bit per clock.
module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_r, r_r, d_r;
  logic [CW-1:0]    left;
  logic             neg_q, neg_r, run, valid_q;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    a_neg   = signed_op & dividend[WIDTH-1];
    b_neg   = signed_op & divisor[WIDTH-1];
    a_mag   = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag   = b_neg ? (~divisor + 1'b1) : divisor;
    shifted = {r_r, q_r[WIDTH-1]};
    // borrow out of bit WIDTH means the trial subtraction must be undone
    trial   = shifted - {1'b0, d_r};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r     <= '0;
      r_r     <= '0;
      d_r     <= '0;
      left    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      run     <= 1'b0;
      valid_q <= 1'b0;
    end else if (abort) begin
      run     <= 1'b0;
      valid_q <= 1'b0;
    end else if (go) begin
      q_r     <= a_mag;
      r_r     <= '0;
      d_r     <= b_mag;
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      left    <= CW'(WIDTH);
      run     <= 1'b1;
      valid_q <= 1'b0;
    end else if (run) begin
      if (!trial[WIDTH]) begin
        r_r <= trial[WIDTH-1:0];
        q_r <= {q_r[WIDTH-2:0], 1'b1};
      end else begin
        r_r <= shifted[WIDTH-1:0];
        q_r <= {q_r[WIDTH-2:0], 1'b0};
      end
      left <= left - 1'b1;
      if (left == CW'(1)) begin
        run     <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

  assign quot  = neg_q ? (~q_r + 1'b1) : q_r;
  assign rem   = neg_r ? (~r_r + 1'b1) : r_r;
  assign valid = valid_q;

endmodule

// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit with HI/LO result registers.
//   state | meaning
//   IDLE  | waiting for an accepted start
//   MUL   | product held, counting out the multiply latency
//   DIV   | iterative divider running
//   FIN   | write HI/LO, pulse done, back to IDLE
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic            clk,
  input  logic            reset,
  md_unit_param_if.slave  md
);

  localparam int CW = $clog2(((WIDTH > MULT_LAT) ? WIDTH : MULT_LAT) + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  md_state_t          state;
  logic [3:0]         op_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   a_q, hi_q, lo_q;
  logic               div_b_zero, busy_q, done_q, dz_q;

  logic               accept, sgn;
  logic [2*WIDTH-1:0] acc, prod, mul_next;
  logic [WIDTH-1:0]   div_quot, div_rem;
  logic               div_valid;

  assign accept = md.start & ~md.cancel & (state == ST_IDLE) & op_is_valid(md.op);

  // Accumulate ops fold into the product at start, so MUL only waits out the latency.
  always_comb begin
    sgn  = op_is_signed(md.op);
    acc  = {hi_q, lo_q};
    prod = {{WIDTH{sgn & md.A[WIDTH-1]}}, md.A} * {{WIDTH{sgn & md.B[WIDTH-1]}}, md.B};
    if (!op_is_acc(md.op))     mul_next = prod;
    else if (op_is_sub(md.op)) mul_next = acc - prod;
    else                       mul_next = acc + prod;
  end

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .go        (accept & op_is_div(md.op)),
    .signed_op (op_is_signed(md.op)),
    .dividend  (md.A),
    .divisor   (md.B),
    .abort     (md.cancel),
    .quot      (div_quot),
    .rem       (div_rem),
    .valid     (div_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      cnt        <= '0;
      mul_res    <= '0;
      a_q        <= '0;
      div_b_zero <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= md.op;
            a_q        <= md.A;
            mul_res    <= mul_next;
            div_b_zero <= (md.B == '0);
            cnt        <= CW'(1);
            busy_q     <= 1'b1;
            if (op_is_mul(md.op))      state <= (MULT_LAT == 1) ? ST_FIN : ST_MUL;
            else if (op_is_div(md.op)) state <= ST_DIV;
            else                       state <= ST_FIN;
          end
        end
        ST_MUL, ST_DIV: begin
          if (md.cancel) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if ((state == ST_MUL && cnt == MUL_LAST) || (state == ST_DIV && cnt == DIV_LAST))
              state <= ST_FIN;
          end
        end
        ST_FIN: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          if (!md.cancel) begin
            done_q <= 1'b1;
            if (op_is_mul(op_q)) begin
              {hi_q, lo_q} <= mul_res;
            end else if (op_is_div(op_q)) begin
              dz_q <= div_b_zero;
              if (!div_b_zero && div_valid) begin
                lo_q <= div_quot;
                hi_q <= div_rem;
              end
            end else if (op_q == MD_MTHI) begin
              hi_q <= a_q;
            end else begin
              lo_q <= a_q;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.busy     = busy_q;
  assign md.done     = done_q;
  assign md.div_zero = dz_q;

endmodule

// File: tb/tb_md_unit_param.sv
// Randomised and directed bench for md_unit_param against an arithmetic reference model.
module tb_md_unit_param;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int ML = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  md_unit_param_if #(.WIDTH(W)) md ();

  md_unit_param #(.WIDTH(W), .MULT_LAT(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the op must produce, from plain 64-bit arithmetic on the current model HI/LO.
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] hi, output logic [W-1:0] lo,
                          output logic dz);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, acc, res;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = a;
    ub  = b;
    acc = {m_hi, m_lo};
    hi  = m_hi;
    lo  = m_lo;
    dz  = 1'b0;
    lat = 0;
    res = acc;
    case (op)
      MD_MULT:  begin res = sa * sb;       lat = ML; end
      MD_MULTU: begin res = ua * ub;       lat = ML; end
      MD_MADD:  begin res = acc + sa * sb; lat = ML; end
      MD_MADDU: begin res = acc + ua * ub; lat = ML; end
      MD_MSUB:  begin res = acc - sa * sb; lat = ML; end
      MD_MSUBU: begin res = acc - ua * ub; lat = ML; end
      MD_DIV, MD_DIVU: begin
        lat = W + 1;
        if (b == '0) dz = 1'b1;
        else if (op == MD_DIV) begin
          q = sa / sb; r = sa % sb;
          res = {r[W-1:0], q[W-1:0]};
        end else begin
          q = longint'(ua / ub); r = longint'(ua % ub);
          res = {r[W-1:0], q[W-1:0]};
        end
      end
      MD_MTHI: begin res = {a, m_lo}; lat = 1; end
      MD_MTLO: begin res = {m_hi, a}; lat = 1; end
      default: lat = 0;
    endcase
    hi = res[63:32];
    lo = res[31:0];
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    int lat, cyc;
    logic [W-1:0] ehi, elo;
    logic edz;
    bit seen;
    model_op(op, a, b, lat, ehi, elo, edz);
    @(negedge clk);
    md.op = op; md.A = a; md.B = b; md.start = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    md.A = $urandom; md.B = $urandom; md.op = 4'($urandom);
    if (lat == 0) begin
      check_val($sformatf("%s_busy_ign", tag), 64'(md.busy), 64'd0);
      @(negedge clk);
      check_val($sformatf("%s_done_ign", tag), 64'(md.done), 64'd0);
      check_val($sformatf("%s_hilo_ign", tag), {md.HI, md.LO}, {m_hi, m_lo});
      return;
    end
    check_val($sformatf("%s_busy0", tag), 64'(md.busy), 64'd1);
    seen = 1'b0;
    cyc = 999;
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge clk);
      if (md.done) begin seen = 1'b1; cyc = n; end
    end
    check_val($sformatf("%s_lat", tag), 64'(cyc), 64'(lat));
    if (!seen) return;
    check_val($sformatf("%s_hi", tag), 64'(md.HI), 64'(ehi));
    check_val($sformatf("%s_lo", tag), 64'(md.LO), 64'(elo));
    check_val($sformatf("%s_dz", tag), 64'(md.div_zero), 64'(edz));
    check_val($sformatf("%s_busy_done", tag), 64'(md.busy), 64'd0);
    m_hi = ehi;
    m_lo = elo;
    @(negedge clk);
    check_val($sformatf("%s_pulse", tag), 64'({md.done, md.div_zero}), 64'd0);
  endtask

  initial begin
    bit seen;
    md.op = '0; md.A = '0; md.B = '0; md.start = 1'b0; md.cancel = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_hilo", {md.HI, md.LO}, 64'd0);
    check_val("rst_flags", 64'({md.busy, md.done, md.div_zero}), 64'd0);
    reset = 1'b1;

    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, "mult");
    check_val("mult_const", {md.HI, md.LO}, 64'hFFFFFFFF_FFFFFFFA);
    run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, "multu");
    check_val("multu_const", {md.HI, md.LO}, 64'h00000002_FFFFFFFA);
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, "div");
    check_val("div_const", {md.HI, md.LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(MD_DIVU, 32'd7, 32'd2, "divu");
    check_val("divu_const", {md.HI, md.LO}, 64'h00000001_00000003);
    run_op(MD_MTHI, 32'h11, 32'd0, "mthi");
    run_op(MD_MTLO, 32'h22, 32'd0, "mtlo");
    run_op(MD_DIV, 32'd5, 32'd0, "div0");
    check_val("div0_const", {md.HI, md.LO}, 64'h00000011_00000022);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, "divmin");
    check_val("divmin_const", {md.HI, md.LO}, 64'h00000000_80000000);
    run_op(MD_MTHI, 32'd5, 32'd0, "mthi5");
    run_op(MD_MTLO, 32'd1, 32'd0, "mtlo1");
    run_op(MD_MSUB, 32'd2, 32'd3, "msub");
    check_val("msub_const", {md.HI, md.LO}, 64'h00000004_FFFFFFFB);
    run_op(MD_MTHI, 32'd0, 32'd0, "mthi0");
    run_op(MD_MTLO, 32'd0, 32'd0, "mtlo0");
    run_op(MD_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, "maddu");
    check_val("maddu_const", {md.HI, md.LO}, 64'hFFFFFFFE_00000001);
    run_op(4'd12, 32'd9, 32'd9, "badop");

    // cancel together with start in IDLE blocks acceptance
    @(negedge clk);
    md.op = MD_MTHI; md.A = 32'h5A5A; md.start = 1'b1; md.cancel = 1'b1;
    @(negedge clk);
    md.start = 1'b0; md.cancel = 1'b0;
    check_val("cancel_blk_busy", 64'(md.busy), 64'd0);
    @(negedge clk);
    check_val("cancel_blk_hilo", {md.HI, md.LO}, {m_hi, m_lo});

    // divu cancelled mid-flight, with an ignored second start
    @(negedge clk);
    md.op = MD_DIVU; md.A = 32'd100; md.B = 32'd7; md.start = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (md.done) seen = 1'b1;
      if (c == 2) begin md.start = 1'b1; md.op = MD_MULT; md.A = 32'd3; md.B = 32'd3; end
      if (c == 3) md.start = 1'b0;
      if (c == 10) begin
        check_val("cancel_busy10", 64'(md.busy), 64'd1);
        md.cancel = 1'b1;
      end
    end
    check_val("cancel_busy11", 64'(md.busy), 64'd0);
    md.cancel = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (md.done || md.busy) seen = 1'b1;
    end
    check_val("cancel_no_done", 64'(seen), 64'd0);
    check_val("cancel_hilo", {md.HI, md.LO}, {m_hi, m_lo});

    // reset in the middle of a multiply
    run_op(MD_MTHI, 32'hDEAD, 32'd0, "pre_rst");
    @(negedge clk);
    md.op = MD_MULT; md.A = 32'd3; md.B = 32'd4; md.start = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_val("midrst_hilo", {md.HI, md.LO}, 64'd0);
    check_val("midrst_busy", 64'(md.busy), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    run_op(MD_MULT, 32'd3, 32'd4, "post_rst");

    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      int           sel;
      op  = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 9));
      run_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
